// File: rtl/aes_enc_iter.sv
// aes_enc_iter: iterative AES-128 encryption core.
//
// A block is accepted with a valid/ready handshake, whitened with the key,
// then ROUNDS_PER_CYCLE rounds are applied per clock until round 10 completes.
// Round keys are expanded on the fly from the previous round key, so no key
// table is stored. The ciphertext is held until the consumer takes it. A new
// block may be accepted on the same edge that the previous one is consumed.
//
// Parameters
//   ROUNDS_PER_CYCLE  rounds per clock, one of 1, 2, 5, 10
//   SBOX_PER_ROUND    S-boxes per datapath round, 16
//
// Ports
//   clk        clock, rising edge
//   reset      synchronous active-high reset
//   in_valid   data_in/key valid
//   in_ready   core can accept a block this cycle
//   data_in    plaintext, byte 0 in [127:120], column-major state
//   key        AES-128 key, same byte order
//   key_load   (AES_KEY_LOAD_EN only) load key into the stored key register
//   out_valid  cipher holds a finished block
//   out_ready  consumer takes cipher this cycle
//   cipher     ciphertext, same byte order
//
// Optional feature macro: AES_KEY_LOAD_EN
//   When defined, the key is taken from a stored key register that is loaded
//   by key_load outside RUN. A load coinciding with an accept edge bypasses
//   the register so that block uses the key being loaded.
module aes_enc_iter #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int SBOX_PER_ROUND   = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic [127:0] key,
`ifdef AES_KEY_LOAD_EN
  input  logic         key_load,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] cipher
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box table built at elaboration: inverse as x^254, then the affine map.
  function automatic logic [2047:0] gen_sbox();
    logic [2047:0] t;
    logic [7:0]    sq;
    logic [7:0]    inv;
    t = '0;
    for (int v = 0; v < 256; v++) begin
      sq  = 8'(v);
      inv = 8'h01;
      for (int k = 1; k < 8; k++) begin
        sq  = gmul(sq, sq);
        inv = gmul(inv, sq);
      end
      t[8*v +: 8] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                    {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    return t;
  endfunction

  localparam logic [2047:0] SBOX_TBL = gen_sbox();

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [4:0] rnd);
    case (rnd)
      5'd1:    return 8'h01;
      5'd2:    return 8'h02;
      5'd3:    return 8'h04;
      5'd4:    return 8'h08;
      5'd5:    return 8'h10;
      5'd6:    return 8'h20;
      5'd7:    return 8'h40;
      5'd8:    return 8'h80;
      5'd9:    return 8'h1b;
      5'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    // RotWord then SubWord on the last word, Rcon into the top byte.
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h000000};
    n0 = k[127:96] ^ t;
    n1 = k[95:64]  ^ n0;
    n2 = k[63:32]  ^ n1;
    n3 = k[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  fsm_t         fsm, fsm_nxt;
  logic [127:0] blk_p0;
  logic [127:0] rkey_p0;
  logic [3:0]   cnt_p0;
  logic [127:0] key_used;
  logic         accept;
  logic         last_step;
  logic [4:0]   last_rnd;
  logic [127:0] st_chain [ROUNDS_PER_CYCLE+1];
  logic [127:0] rk_chain [ROUNDS_PER_CYCLE+1];

`ifdef AES_KEY_LOAD_EN
  logic [127:0] key_store;

  always_ff @(posedge clk) begin
    if (reset) key_store <= '0;
    else if (key_load && fsm != RUN) key_store <= key;
  end

  assign key_used = key_load ? key : key_store;
`else
  assign key_used = key;
`endif

  // ---- combinational round cascade: rounds cnt_p0 .. cnt_p0+ROUNDS_PER_CYCLE-1
  assign st_chain[0] = blk_p0;
  assign rk_chain[0] = rkey_p0;

  for (genvar r = 0; r < ROUNDS_PER_CYCLE; r++) begin : g_round
    logic [4:0]   rnd;
    logic [127:0] sb;
    assign rnd = {1'b0, cnt_p0} + 5'(r);
    for (genvar i = 0; i < SBOX_PER_ROUND; i++) begin : g_sbox
      assign sb[127 - 8*i -: 8] = sbox(st_chain[r][127 - 8*i -: 8]);
    end
    assign rk_chain[r+1] = next_key(rk_chain[r], rcon(rnd));
    // The final round skips MixColumns.
    assign st_chain[r+1] = ((rnd == 5'd10) ? shift_rows(sb) : mix_columns(shift_rows(sb)))
                           ^ rk_chain[r+1];
  end

  assign last_rnd  = {1'b0, cnt_p0} + 5'(ROUNDS_PER_CYCLE - 1);
  assign last_step = (last_rnd == 5'd10);

  // ---- control
  always_ff @(posedge clk) begin
    if (reset) fsm <= IDLE;
    else       fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt  = fsm;
    in_ready = 1'b0;
    case (fsm)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) fsm_nxt = RUN;
      end
      RUN: begin
        if (last_step) fsm_nxt = DONE;
      end
      DONE: begin
        if (out_ready) begin
          in_ready = 1'b1;
          fsm_nxt  = in_valid ? RUN : IDLE;
        end
      end
      default: fsm_nxt = IDLE;
    endcase
    if (reset) in_ready = 1'b0;
  end

  assign accept    = in_valid & in_ready;
  assign out_valid = (fsm == DONE);
  assign cipher    = blk_p0;

  // ---- state / round-key registers
  always_ff @(posedge clk) begin
    if (reset) begin
      blk_p0  <= '0;
      rkey_p0 <= '0;
      cnt_p0  <= '0;
    end else if (accept) begin
      blk_p0  <= data_in ^ key_used;
      rkey_p0 <= key_used;
      cnt_p0  <= 4'd1;
    end else if (fsm == RUN) begin
      blk_p0  <= st_chain[ROUNDS_PER_CYCLE];
      rkey_p0 <= rk_chain[ROUNDS_PER_CYCLE];
      cnt_p0  <= cnt_p0 + 4'(ROUNDS_PER_CYCLE);
    end
  end

endmodule

// File: tb/tb_aes_enc_iter.sv
// Testbench for aes_enc_iter: four instances (1, 2, 5, 10 rounds per cycle)
// checked against known-answer vectors and a byte-array AES-128 model.
module tb_aes_enc_iter;

  logic         clk = 1'b0;
  logic         reset;
  logic         iv [4];
  logic         ir [4];
  logic         ov [4];
  logic         ordy [4];
  logic [127:0] din [4];
  logic [127:0] kin [4];
  logic [127:0] ciph [4];
`ifdef AES_KEY_LOAD_EN
  logic         kl [4];
`endif

  int checks = 0;
  int passed = 0;
  logic [7:0] sbt [256];

  typedef struct {
    logic [127:0] k;
    logic [127:0] p;
    logic [127:0] c;
  } vec_t;
  vec_t vt [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int RPC = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10;
    aes_enc_iter #(.ROUNDS_PER_CYCLE(RPC), .SBOX_PER_ROUND(16)) u_dut (
      .clk(clk),
      .reset(reset),
      .in_valid(iv[g]),
      .in_ready(ir[g]),
      .data_in(din[g]),
      .key(kin[g]),
`ifdef AES_KEY_LOAD_EN
      .key_load(kl[g]),
`endif
      .out_valid(ov[g]),
      .out_ready(ordy[g]),
      .cipher(ciph[g])
    );
  end

  function automatic int rpc_of(input int d);
    case (d)
      0:       return 1;
      1:       return 2;
      2:       return 5;
      default: return 10;
    endcase
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c63;
    c63 = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c63[i];
      sbt[x] = s;
    end
  endtask

  // Textbook AES-128: full key schedule into 44 words, then 10 rounds on a 4x4 byte state.
  function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
    logic [7:0]   w [44][4];
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   tmp [4];
    logic [7:0]   rc;
    logic [127:0] o;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        w[i][j] = k[127 - 8*(4*i + j) -: 8];
        s[i][j] = p[127 - 8*(4*i + j) -: 8];
      end
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[i-1][j];
      if (i % 4 == 0) begin
        tmp[0] = sbt[w[i-1][1]] ^ rc;
        tmp[1] = sbt[w[i-1][2]];
        tmp[2] = sbt[w[i-1][3]];
        tmp[3] = sbt[w[i-1][0]];
        rc = gm(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ tmp[j];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[c][r] = s[c][r] ^ w[c][r];
    for (int n = 1; n <= 10; n++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[c][r] = sbt[s[(c+r)%4][r]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[c][r] = (n < 10) ? (gm(8'h02, t[c][r]) ^ gm(8'h03, t[c][(r+1)%4]) ^
                                t[c][(r+2)%4] ^ t[c][(r+3)%4]) : t[c][r];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[c][r] = s[c][r] ^ w[4*n + c][r];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) o[127 - 8*(4*c + r) -: 8] = s[c][r];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask

  task automatic accept(input int d, input logic [127:0] k, input logic [127:0] p, input string nm);
    iv[d]  = 1'b1;
    din[d] = p;
    kin[d] = k;
`ifdef AES_KEY_LOAD_EN
    kl[d] = 1'b1;
`endif
    chk({nm, "_in_ready"}, 128'(ir[d]), 128'(1));
    tick();
    iv[d]  = 1'b0;
    din[d] = rand128();
    kin[d] = rand128();
`ifdef AES_KEY_LOAD_EN
    kl[d] = 1'b0;
`endif
  endtask

  task automatic wait_out(input int d, input bit scramble, output int lat);
    lat = 0;
    if (scramble) begin
      iv[d]   = 1'($urandom_range(0, 1));
      ordy[d] = 1'($urandom_range(0, 1));
    end
    while (ov[d] !== 1'b1 && lat < 40) begin
      tick();
      lat++;
      if (scramble && ov[d] !== 1'b1) begin
        iv[d]   = 1'($urandom_range(0, 1));
        ordy[d] = 1'($urandom_range(0, 1));
        din[d]  = rand128();
        kin[d]  = rand128();
      end
    end
    if (scramble) begin
      iv[d]   = 1'b0;
      ordy[d] = 1'b0;
    end
  endtask

  task automatic consume(input int d, input string nm);
    iv[d]   = 1'b0;
    ordy[d] = 1'b1;
    tick();
    ordy[d] = 1'b0;
    chk({nm, "_ov_drop"}, 128'(ov[d]), 128'(0));
    chk({nm, "_idle_ready"}, 128'(ir[d]), 128'(1));
  endtask

  task automatic run_one(input int d, input logic [127:0] k, input logic [127:0] p,
                         input logic [127:0] exp, input int stall, input string nm);
    int lat;
    accept(d, k, p, nm);
    wait_out(d, 1'b1, lat);
    chk({nm, "_latency"}, 128'(lat), 128'(10 / rpc_of(d)));
    for (int i = 0; i < stall; i++) tick();
    chk({nm, "_cipher"}, ciph[d], exp);
    consume(d, nm);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    bit rose;
    logic [127:0] k, p;

    reset = 1'b1;
    for (int d = 0; d < 4; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b0; din[d] = '0; kin[d] = '0;
`ifdef AES_KEY_LOAD_EN
      kl[d] = 1'b0;
`endif
    end
    build_sbox();

    vt[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vt[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
              128'h3925841d02dc09fbdc118597196a0b32};
    vt[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    // Reset state
    tick();
    tick();
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("rst_in_ready_rpc%0d", rpc_of(d)), 128'(ir[d]), 128'(0));
      chk($sformatf("rst_out_valid_rpc%0d", rpc_of(d)), 128'(ov[d]), 128'(0));
      chk($sformatf("rst_cipher_rpc%0d", rpc_of(d)), ciph[d], 128'(0));
    end
    reset = 1'b0;
    #1;
    for (int d = 0; d < 4; d++)
      chk($sformatf("post_rst_in_ready_rpc%0d", rpc_of(d)), 128'(ir[d]), 128'(1));

    // Known-answer table on every configuration
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model_v%0d", i), aes_ref(vt[i].k, vt[i].p), vt[i].c);
      for (int d = 0; d < 4; d++)
        run_one(d, vt[i].k, vt[i].p, vt[i].c, 0, $sformatf("kat%0d_rpc%0d", i, rpc_of(d)));
    end

    // Output stall: all-zero vector held 20 cycles with out_ready low
    accept(0, vt[2].k, vt[2].p, "stall");
    wait_out(0, 1'b0, lat);
    chk("stall_latency", 128'(lat), 128'(10));
    for (int i = 0; i < 20; i++) begin
      iv[0]  = 1'b1;
      din[0] = rand128();
      tick();
      chk($sformatf("stall%0d_out_valid", i), 128'(ov[0]), 128'(1));
      chk($sformatf("stall%0d_in_ready", i), 128'(ir[0]), 128'(0));
      chk($sformatf("stall%0d_cipher", i), ciph[0], vt[2].c);
    end
    consume(0, "stall");

    // Back-to-back: second accept on the edge the first result is consumed
    for (int j = 0; j < 2; j++) begin
      int d;
      d = (j == 0) ? 0 : 3;
      ordy[d] = 1'b1;
      iv[d]   = 1'b1;
      din[d]  = vt[0].p;
      kin[d]  = vt[0].k;
`ifdef AES_KEY_LOAD_EN
      kl[d] = 1'b1;
`endif
      tick();
      din[d] = vt[1].p;
      kin[d] = vt[1].k;
      wait_out(d, 1'b0, lat);
      chk($sformatf("b2b_a_latency_rpc%0d", rpc_of(d)), 128'(lat), 128'(10 / rpc_of(d)));
      chk($sformatf("b2b_a_cipher_rpc%0d", rpc_of(d)), ciph[d], vt[0].c);
      chk($sformatf("b2b_ready_rpc%0d", rpc_of(d)), 128'(ir[d]), 128'(1));
      tick();
      iv[d] = 1'b0;
`ifdef AES_KEY_LOAD_EN
      kl[d] = 1'b0;
`endif
      chk($sformatf("b2b_no_bubble_rpc%0d", rpc_of(d)), 128'(ov[d]), 128'(0));
      wait_out(d, 1'b0, lat);
      chk($sformatf("b2b_b_latency_rpc%0d", rpc_of(d)), 128'(lat), 128'(10 / rpc_of(d)));
      chk($sformatf("b2b_b_cipher_rpc%0d", rpc_of(d)), ciph[d], vt[1].c);
      tick();
      ordy[d] = 1'b0;
      chk($sformatf("b2b_idle_rpc%0d", rpc_of(d)), 128'(ov[d]), 128'(0));
    end

    // Reset in the middle of a block
    accept(0, vt[1].k, vt[1].p, "midrst");
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    chk("midrst_out_valid", 128'(ov[0]), 128'(0));
    chk("midrst_cipher", ciph[0], 128'(0));
    chk("midrst_in_ready_during", 128'(ir[0]), 128'(0));
    reset = 1'b0;
    #1;
    chk("midrst_in_ready_after", 128'(ir[0]), 128'(1));
    rose = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (ov[0] === 1'b1) rose = 1'b1;
    end
    chk("midrst_no_out_valid", 128'(rose), 128'(0));
    run_one(0, vt[0].k, vt[0].p, vt[0].c, 0, "midrst_fresh");

`ifdef AES_KEY_LOAD_EN
    // Stored key: load once, then encrypt with key input held at zero
    kl[0]  = 1'b1;
    kin[0] = vt[0].k;
    tick();
    kl[0]  = 1'b0;
    kin[0] = '0;
    iv[0]  = 1'b1;
    din[0] = vt[0].p;
    tick();
    iv[0] = 1'b0;
    wait_out(0, 1'b0, lat);
    chk("keyload_latency", 128'(lat), 128'(10));
    chk("keyload_cipher", ciph[0], vt[0].c);
    consume(0, "keyload");
`endif

    // Randomized blocks against the reference model
    for (int n = 0; n < 12; n++) begin
      for (int d = 0; d < 4; d++) begin
        k = rand128();
        p = rand128();
        run_one(d, k, p, aes_ref(k, p), $urandom_range(0, 3),
                $sformatf("rand%0d_rpc%0d", n, rpc_of(d)));
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
